// File: rtl/sram_responder.sv
// Queued single-port SRAM responder: zero-fill sweep after reset, then in-order masked writes and pipelined reads.
// Optional macro SRAM_RESPONDER_STALL_EN adds LFSR-driven pseudo-random backpressure on sram_ready.
module sram_responder #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 32,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 2
) (
    input  logic                      sram_clock,
    input  logic                      reset,
    input  logic                      sram_addr_valid,
    output logic                      sram_ready,
    input  logic [ADDR_WIDTH-1:0]     sram_addr,
    input  logic [DATA_WIDTH-1:0]     sram_data_in,
    input  logic [DATA_WIDTH/8-1:0]   sram_write_mask,
    output logic [DATA_WIDTH-1:0]     sram_data_out,
    output logic                      sram_data_out_valid,
    output logic                      clearing
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int WORDS = 1 << ADDR_WIDTH;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_addr;
    logic [DATA_WIDTH-1:0]   mem [WORDS];

    logic [ADDR_WIDTH-1:0]   q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]   q_data [FIFO_DEPTH];
    logic [BYTES-1:0]        q_mask [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W:0]          count;

    logic                    stall;
    logic                    push;
    logic                    pop;
    logic [ADDR_WIDTH-1:0]   head_addr;
    logic [DATA_WIDTH-1:0]   head_data;
    logic [BYTES-1:0]        head_mask;
    logic                    head_is_write;

    logic [DATA_WIDTH-1:0]   data_p [READ_LATENCY];
    logic [READ_LATENCY-1:0] vld_p;

`ifdef SRAM_RESPONDER_STALL_EN
    logic [15:0] lfsr;

    // Fibonacci LFSR, taps 16,14,13,11
    always_ff @(posedge sram_clock) begin
        if (!reset) lfsr <= 16'hACE1;
        else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end

    assign stall = (lfsr[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign sram_ready    = (state == RUN) && (count < DEPTH_C) && !stall;
    assign push          = sram_addr_valid && sram_ready;
    assign pop           = (state == RUN) && (count != '0);
    assign head_addr     = q_addr[rd_ptr];
    assign head_data     = q_data[rd_ptr];
    assign head_mask     = q_mask[rd_ptr];
    assign head_is_write = |head_mask;

    always_ff @(posedge sram_clock) begin
        if (!reset) begin
            state    <= CLEAR;
            clr_addr <= '0;
            clearing <= 1'b1;
        end else begin
            case (state)
                CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == '1) begin
                        state    <= RUN;
                        clearing <= 1'b0;
                    end
                end
                RUN: ;
                default: state <= CLEAR;
            endcase
        end
    end

    always_ff @(posedge sram_clock) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge sram_clock) begin
        if (push) begin
            q_addr[wr_ptr] <= sram_addr;
            q_data[wr_ptr] <= sram_data_in;
            q_mask[wr_ptr] <= sram_write_mask;
        end
    end

    // Issue stage: the sweep owns the array until RUN, then the queue head writes
    always_ff @(posedge sram_clock) begin
        if (state == CLEAR) begin
            mem[clr_addr] <= '0;
        end else if (pop && head_is_write) begin
            for (int b = 0; b < BYTES; b++)
                if (head_mask[b]) mem[head_addr][b*8 +: 8] <= head_data[b*8 +: 8];
        end
    end

    // Read stage _p0 captures memory at issue; later stages only delay
    always_ff @(posedge sram_clock) begin
        data_p[0] <= mem[head_addr];
        for (int i = 1; i < READ_LATENCY; i++)
            data_p[i] <= data_p[i-1];
    end

    always_ff @(posedge sram_clock) begin
        if (!reset) begin
            vld_p <= '0;
        end else begin
            vld_p[0] <= pop && !head_is_write;
            for (int i = 1; i < READ_LATENCY; i++)
                vld_p[i] <= vld_p[i-1];
        end
    end

    // Output stage: data holds its last read value between pulses
    always_ff @(posedge sram_clock) begin
        if (!reset) begin
            sram_data_out_valid <= 1'b0;
            sram_data_out       <= '0;
        end else begin
            sram_data_out_valid <= vld_p[READ_LATENCY-1];
            if (vld_p[READ_LATENCY-1]) sram_data_out <= data_p[READ_LATENCY-1];
        end
    end

endmodule
